tff_bank_counter: RTL and testbench
===================================

// Module: tff_bank_counter
// PURPOSE
//  Parametrised bank of WIDTH T flip-flops sharing one clock, enable and sync set/clear.
//  Runs as independent toggle cells (per-bit T inputs) or as a synchronous up/down counter.
//  Counter mode is built on T-chain semantics: bit i toggles when all lower bits are 1 (up) or 0 (down).
//  Used as a general toggle register, event counter and divider in the VLSI-project datapaths.
// PARAMETERS
//  WIDTH      4   number of T flip-flops / counter bits (>=1)
//  RESET_VAL  0   value of q after async reset (WIDTH bits)
//  SATURATE   0   0: counter wraps at terminal value; 1: counter holds at terminal value
// PORTS
//  clk       in   1      rising-edge clock
//  reset_n   in   1      asynchronous reset, active-low
//  en        in   1      global enable; 0 freezes q (set/clr/load still need en=1)
//  clr       in   1      synchronous clear, q <= 0
//  set       in   1      synchronous set, q <= all ones
//  load      in   1      synchronous parallel load, q <= d
//  d         in   WIDTH  load data
//  mode      in   2      00 HOLD, 01 TOGGLE, 10 UP, 11 DOWN
//  t         in   WIDTH  per-bit toggle request (TOGGLE mode only)
//  q         out  WIDTH  flip-flop state
//  tc        out  1      terminal count: UP & q==all ones, or DOWN & q==0; 0 in HOLD/TOGGLE
//  ovf       out  1      registered 1-cycle pulse: counter wrapped or hit saturation limit
// BEHAVIOUR
//  - Reset (reset_n=0, async, any time): q <= RESET_VAL, ovf <= 0; tc follows q/mode combinationally.
//  - en=0: q and ovf hold... ovf drops to 0 (pulse only), q holds; all other inputs ignored.
//  - en=1, priority per rising edge: clr > set > load > mode operation.
//    clr: q <= 0.  set: q <= {WIDTH{1}}.  load: q <= d.  ovf <= 0 for all three.
//  - HOLD: q unchanged.
//  - TOGGLE: q <= q ^ t (bit i flips iff t[i]=1); ovf <= 0.
//  - UP: toggle vector tv[0]=1, tv[i]=&q[i-1:0]; q <= q ^ tv (equals q+1 mod 2^WIDTH).
//  - DOWN: tv[0]=1, tv[i]=&~q[i-1:0]; q <= q ^ tv (equals q-1 mod 2^WIDTH).
//  - Terminal edge (UP with q=all ones, or DOWN with q=0, en=1, no clr/set/load):
//    SATURATE=0: q wraps (all ones->0, 0->all ones), ovf <= 1 next cycle.
//    SATURATE=1: q unchanged, ovf <= 1 next cycle (every such edge while held).
//  - ovf is 0 on every edge that is not a terminal edge; never high two cycles unless terminal repeats.
//  - Latency: all q updates visible 1 cycle after edge; tc is combinational from q and mode.
//  - Mode change mid-count: takes effect on next edge, q not altered by the change itself.
//  - Reset mid-operation: async, overrides pending load/set/clr; first post-reset edge acts normally.
//  - WIDTH=1: UP and DOWN both toggle q every edge; tc per rule above.
// TESTING
//  1 reset_n=0 mid-count, WIDTH=4, RESET_VAL=4'h5 -> q=4'h5 immediately, ovf=0, no clk needed.
//  2 en=1, mode=01, q=0, t=4'b1010 for 3 edges -> q: 1010,0000,1010; ovf stays 0.
//  3 mode=10 from q=4'hE, SATURATE=0 -> q: F (tc=1), 0 with ovf=1 for 1 cycle, then 1, ovf=0.
//  4 SATURATE=1, mode=11 from q=4'h1 -> q: 0 (tc=1), 0 with ovf=1, stays 0, ovf=1 each edge.
//  5 clr=set=load=1, d=4'h9, q=4'h7 -> q=0; then clr=0 -> q=F; then set=0 -> q=9.
//  6 en=0 with mode=10, load=1, clr=1 for 4 edges, q=4'h3 -> q stays 3, ovf=0.

Source files
------------

// File: rtl/tff_bank_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tff_bank_counter
//  Description : Bank of WIDTH T flip-flops sharing clock, enable and
//                synchronous set/clear/load. Operates either as independent
//                toggle cells (per-bit t) or as a synchronous up/down counter
//                built from T-chain toggle vectors.
//  Ports       : clk      - rising-edge clock
//                reset_n  - asynchronous reset, active-low (q <= RESET_VAL)
//                en       - global enable; 0 freezes q, ovf returns to 0
//                clr      - synchronous clear (highest priority)
//                set      - synchronous set to all ones
//                load     - synchronous parallel load of d
//                d        - load data
//                mode     - 00 HOLD, 01 TOGGLE, 10 UP, 11 DOWN
//                t        - per-bit toggle request (TOGGLE mode)
//                q        - flip-flop state
//                tc       - terminal count (combinational from q and mode)
//                ovf      - registered one-cycle wrap/saturation pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module tff_bank_counter #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit               SATURATE  = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             clr,
    input  logic             set,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf
);

    localparam logic [1:0] c_MODE_HOLD   = 2'b00;
    localparam logic [1:0] c_MODE_TOGGLE = 2'b01;
    localparam logic [1:0] c_MODE_UP     = 2'b10;
    localparam logic [1:0] c_MODE_DOWN   = 2'b11;

    logic [WIDTH-1:0] r_q;
    logic             r_ovf;
    logic [WIDTH-1:0] w_tv_up;
    logic [WIDTH-1:0] w_tv_dn;
    logic             w_all_ones;
    logic             w_all_zero;
    logic [WIDTH-1:0] w_q_next;
    logic             w_ovf_next;

    assign w_all_ones = &r_q;
    assign w_all_zero = ~|r_q;

    // T-chain: a bit toggles when every lower bit is 1 (up) or 0 (down).
    // Each stage reuses the previous stage's AND, forming a ripple chain.
    assign w_tv_up[0] = 1'b1;
    assign w_tv_dn[0] = 1'b1;

    generate
        for (genvar i = 1; i < WIDTH; i++) begin : g_chain
            assign w_tv_up[i] = w_tv_up[i-1] &  r_q[i-1];
            assign w_tv_dn[i] = w_tv_dn[i-1] & ~r_q[i-1];
        end
    endgenerate

    always_comb begin
        w_q_next   = r_q;
        w_ovf_next = 1'b0;
        if (clr) begin
            w_q_next = '0;
        end else if (set) begin
            w_q_next = '1;
        end else if (load) begin
            w_q_next = d;
        end else begin
            case (mode)
                c_MODE_HOLD: begin
                    w_q_next = r_q;
                end
                c_MODE_TOGGLE: begin
                    w_q_next = r_q ^ t;
                end
                c_MODE_UP: begin
                    // At all-ones the full chain is set, so q ^ tv wraps to 0.
                    w_ovf_next = w_all_ones;
                    if (!(SATURATE && w_all_ones)) begin
                        w_q_next = r_q ^ w_tv_up;
                    end
                end
                c_MODE_DOWN: begin
                    // At zero the full chain is set, so q ^ tv wraps to all ones.
                    w_ovf_next = w_all_zero;
                    if (!(SATURATE && w_all_zero)) begin
                        w_q_next = r_q ^ w_tv_dn;
                    end
                end
                default: begin
                    w_q_next = r_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q   <= RESET_VAL;
            r_ovf <= 1'b0;
        end else if (en) begin
            r_q   <= w_q_next;
            r_ovf <= w_ovf_next;
        end else begin
            // ovf is a pulse: it never stays high while the bank is frozen.
            r_ovf <= 1'b0;
        end
    end

    assign q   = r_q;
    assign ovf = r_ovf;
    assign tc  = ((mode == c_MODE_UP)   && w_all_ones) ||
                 ((mode == c_MODE_DOWN) && w_all_zero);

endmodule
`default_nettype wire

// File: tb/tb_tff_bank_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tff_bank_counter
//  Description : Scoreboard bench for tff_bank_counter. Two instances share
//                all inputs: one wrapping (SATURATE=0), one saturating
//                (SATURATE=1), both WIDTH=4, RESET_VAL=4'h5. Stimulus pushes
//                hand-computed expectations; a monitor pops and compares on
//                each falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tff_bank_counter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       en, clr, set, load;
    logic [3:0] d, t;
    logic [1:0] mode;

    logic [3:0] q_w, q_s;
    logic       tc_w, tc_s, ovf_w, ovf_s;

    typedef struct {
        string      name;
        logic [3:0] qw;
        logic       tcw;
        logic       ovw;
        logic [3:0] qs;
        logic       tcs;
        logic       ovs;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    tff_bank_counter #(.WIDTH(4), .RESET_VAL(4'h5), .SATURATE(1'b0)) u_dut_wrap (
        .clk(clk), .reset_n(reset_n), .en(en), .clr(clr), .set(set), .load(load),
        .d(d), .mode(mode), .t(t), .q(q_w), .tc(tc_w), .ovf(ovf_w)
    );

    tff_bank_counter #(.WIDTH(4), .RESET_VAL(4'h5), .SATURATE(1'b1)) u_dut_sat (
        .clk(clk), .reset_n(reset_n), .en(en), .clr(clr), .set(set), .load(load),
        .d(d), .mode(mode), .t(t), .q(q_s), .tc(tc_s), .ovf(ovf_s)
    );

    task automatic chk(input string nm, input string fld, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
        end
    endtask

    // Monitor: outputs are stable mid-cycle, compare one expectation per falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk(e.name, "wrap.q",   q_w,          e.qw);
                chk(e.name, "wrap.tc",  {3'b0, tc_w},  {3'b0, e.tcw});
                chk(e.name, "wrap.ovf", {3'b0, ovf_w}, {3'b0, e.ovw});
                chk(e.name, "sat.q",    q_s,          e.qs);
                chk(e.name, "sat.tc",   {3'b0, tc_s},  {3'b0, e.tcs});
                chk(e.name, "sat.ovf",  {3'b0, ovf_s}, {3'b0, e.ovs});
            end
        end
    end

    // Watchdog so the bench always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic push(input string nm, input logic [3:0] qw, input logic tcw, input logic ovw,
                        input logic [3:0] qs, input logic tcs, input logic ovs);
        exp_t e;
        e.name = nm; e.qw = qw; e.tcw = tcw; e.ovw = ovw;
        e.qs = qs; e.tcs = tcs; e.ovs = ovs;
        sb.push_back(e);
    endtask

    // Drive inputs, take one rising edge, queue the expected post-edge state,
    // then leave inputs stable until just after the monitor's falling edge.
    task automatic step(input string nm, input logic e_en, input logic e_clr, input logic e_set,
                        input logic e_load, input logic [1:0] e_mode, input logic [3:0] e_d,
                        input logic [3:0] e_t,
                        input logic [3:0] qw, input logic tcw, input logic ovw,
                        input logic [3:0] qs, input logic tcs, input logic ovs);
        en = e_en; clr = e_clr; set = e_set; load = e_load;
        mode = e_mode; d = e_d; t = e_t;
        @(posedge clk);
        #1;
        push(nm, qw, tcw, ovw, qs, tcs, ovs);
        @(negedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        en = 1'b1; clr = 1'b0; set = 1'b0; load = 1'b0;
        mode = 2'b00; d = 4'h0; t = 4'h0;
        #1;
        push("reset", 4'h5, 1'b0, 1'b0, 4'h5, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        reset_n = 1'b1;

        //    name            en clr set ld mode   d      t        qW   tcW  ovW   qS   tcS  ovS
        step("hold",         1, 0, 0, 0, 2'b00, 4'h0, 4'h0,    4'h5, 0, 0,    4'h5, 0, 0);
        step("clr",          1, 1, 0, 0, 2'b00, 4'h0, 4'h0,    4'h0, 0, 0,    4'h0, 0, 0);
        step("tog1",         1, 0, 0, 0, 2'b01, 4'h0, 4'hA,    4'hA, 0, 0,    4'hA, 0, 0);
        step("tog2",         1, 0, 0, 0, 2'b01, 4'h0, 4'hA,    4'h0, 0, 0,    4'h0, 0, 0);
        step("tog3",         1, 0, 0, 0, 2'b01, 4'h0, 4'hA,    4'hA, 0, 0,    4'hA, 0, 0);
        step("load_e",       1, 0, 0, 1, 2'b00, 4'hE, 4'h0,    4'hE, 0, 0,    4'hE, 0, 0);
        step("up_to_f",      1, 0, 0, 0, 2'b10, 4'h0, 4'h0,    4'hF, 1, 0,    4'hF, 1, 0);
        step("up_term",      1, 0, 0, 0, 2'b10, 4'h0, 4'h0,    4'h0, 0, 1,    4'hF, 1, 1);
        step("up_after",     1, 0, 0, 0, 2'b10, 4'h0, 4'h0,    4'h1, 0, 0,    4'hF, 1, 1);
        step("load_over_dn", 1, 0, 0, 1, 2'b11, 4'h1, 4'h0,    4'h1, 0, 0,    4'h1, 0, 0);
        step("dn_to_0",      1, 0, 0, 0, 2'b11, 4'h0, 4'h0,    4'h0, 1, 0,    4'h0, 1, 0);
        step("dn_term",      1, 0, 0, 0, 2'b11, 4'h0, 4'h0,    4'hF, 0, 1,    4'h0, 1, 1);
        step("dn_after",     1, 0, 0, 0, 2'b11, 4'h0, 4'h0,    4'hE, 0, 0,    4'h0, 1, 1);
        step("load_7",       1, 0, 0, 1, 2'b00, 4'h7, 4'h0,    4'h7, 0, 0,    4'h7, 0, 0);
        step("prio_clr",     1, 1, 1, 1, 2'b00, 4'h9, 4'h0,    4'h0, 0, 0,    4'h0, 0, 0);
        step("prio_set",     1, 0, 1, 1, 2'b00, 4'h9, 4'h0,    4'hF, 0, 0,    4'hF, 0, 0);
        step("prio_load",    1, 0, 0, 1, 2'b00, 4'h9, 4'h0,    4'h9, 0, 0,    4'h9, 0, 0);
        step("load_3",       1, 0, 0, 1, 2'b00, 4'h3, 4'h0,    4'h3, 0, 0,    4'h3, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step("en0_freeze", 0, 1, 0, 1, 2'b10, 4'h9, 4'h0,  4'h3, 0, 0,    4'h3, 0, 0);
        end
        step("load_f",       1, 0, 0, 1, 2'b10, 4'hF, 4'h0,    4'hF, 1, 0,    4'hF, 1, 0);
        step("up_term2",     1, 0, 0, 0, 2'b10, 4'h0, 4'h0,    4'h0, 0, 1,    4'hF, 1, 1);
        step("en0_ovf_drop", 0, 0, 0, 0, 2'b10, 4'h0, 4'h0,    4'h0, 0, 0,    4'hF, 1, 0);
        step("mode_change",  1, 0, 0, 0, 2'b01, 4'h0, 4'h0,    4'h0, 0, 0,    4'hF, 0, 0);
        step("up_resume",    1, 0, 0, 0, 2'b10, 4'h0, 4'h0,    4'h1, 0, 0,    4'hF, 1, 1);

        // Asynchronous reset in the high phase, with a load pending: the next
        // falling edge must already show RESET_VAL without any rising edge.
        load = 1'b1; d = 4'hC;
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        push("async_reset", 4'h5, 1'b0, 1'b0, 4'h5, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        reset_n = 1'b1;

        step("post_rst_load",1, 0, 0, 1, 2'b00, 4'hC, 4'h0,    4'hC, 0, 0,    4'hC, 0, 0);
        step("post_rst_dn",  1, 0, 0, 0, 2'b11, 4'h0, 4'h0,    4'hB, 0, 0,    4'hB, 0, 0);

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
